uart_tx_sched: RTL and testbench

//  Shares the single UART transmitter between two byte sources: the RX echo path and
//  the result encoder's ASCII byte stream. A result message is sent atomically; once its

---
 rtl/uart_cal_pkg.sv | 15 +
 rtl/uart_tx_sched_fifo.sv | 70 +++++++
 rtl/uart_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cal_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states and the
// CR/LF suffix bytes appended after each result message.
package uart_cal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RES  = 2'd1,
    ST_CR   = 2'd2,
    ST_LF   = 2'd3
  } sched_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Small first-word-fall-through byte FIFO used to buffer echo bytes.
// A push while full is ignored; push and pop together leave the count unchanged.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage carries no reset; stale entries are never visible while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates the single UART transmitter between buffered echo bytes and
// result messages. A message is sent atomically once its first byte is taken,
// optionally followed by CR/LF. Echo bursts are capped while a result waits.
module uart_tx_sched
  import uart_cal_pkg::*;
#(
  parameter int ECHO_DEPTH     = 4,
  parameter int MAX_ECHO_BURST = 4,
  parameter int APPEND_CRLF    = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  output logic       echo_ready,
  output logic       echo_drop,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  input  logic       res_last,
  output logic       res_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  output logic       msg_busy
);

  localparam int             BW        = $clog2(MAX_ECHO_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_ECHO_BURST);

  sched_state_e  state_q, state_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          msg_busy_q, msg_busy_d;
  logic          echo_drop_q, echo_drop_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          slot_free, grant_echo, grant_res;

  function automatic logic [BW-1:0] burst_sat_inc(input logic [BW-1:0] b);
    return (b == BURST_MAX) ? b : b + 1'b1;
  endfunction

  uart_byte_fifo #(.DEPTH(ECHO_DEPTH)) u_echo_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (echo_valid),
    .din   (echo_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // The output register may take a new byte when empty or being handed off now
  assign slot_free  = !tx_valid_q || tx_ready;
  assign grant_echo = (state_q == ST_IDLE) && !fifo_empty &&
                      !(res_valid && (burst_q == BURST_MAX));
  assign grant_res  = (state_q == ST_IDLE) && !grant_echo && res_valid;

  assign echo_ready = !fifo_full;
  assign echo_drop  = echo_drop_q;
  assign tx_valid   = tx_valid_q;
  assign tx_byte    = tx_byte_q;
  assign msg_busy   = msg_busy_q;

  // Scheduler: decides what the output register loads next and where the FSM goes
  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    msg_busy_d  = msg_busy_q;
    burst_d     = burst_q;
    fifo_pop    = 1'b0;
    res_ready   = 1'b0;
    echo_drop_d = echo_valid && fifo_full;

    // The burst limit only matters while a result is actually waiting
    if ((state_q == ST_IDLE) && !res_valid) begin
      burst_d = '0;
    end

    if (slot_free) begin
      tx_valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_echo) begin
            fifo_pop   = 1'b1;
            tx_valid_d = 1'b1;
            tx_byte_d  = fifo_dout;
            if (res_valid) begin
              burst_d = burst_sat_inc(burst_q);
            end
          end else if (grant_res) begin
            res_ready  = 1'b1;
            tx_valid_d = 1'b1;
            tx_byte_d  = res_data;
            burst_d    = '0;
            msg_busy_d = 1'b1;
            if (res_last) begin
              if (APPEND_CRLF != 0) begin
                state_d = ST_CR;
              end else begin
                msg_busy_d = 1'b0;
              end
            end else begin
              state_d = ST_RES;
            end
          end
        end
        ST_RES: begin
          // Echo stays in the FIFO so no byte is interleaved into the message
          if (res_valid) begin
            res_ready  = 1'b1;
            tx_valid_d = 1'b1;
            tx_byte_d  = res_data;
            if (res_last) begin
              if (APPEND_CRLF != 0) begin
                state_d = ST_CR;
              end else begin
                state_d    = ST_IDLE;
                msg_busy_d = 1'b0;
              end
            end
          end
        end
        ST_CR: begin
          tx_valid_d = 1'b1;
          tx_byte_d  = ASCII_CR;
          state_d    = ST_LF;
        end
        ST_LF: begin
          tx_valid_d = 1'b1;
          tx_byte_d  = ASCII_LF;
          state_d    = ST_IDLE;
          msg_busy_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered state and outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      msg_busy_q  <= 1'b0;
      echo_drop_q <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      msg_busy_q  <= msg_busy_d;
      echo_drop_q <= echo_drop_d;
      burst_q     <= burst_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched. Three instances share one stimulus:
// u0 depth 4 with CR/LF, u1 depth 4 without suffix, u2 depth 8 with CR/LF.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       echo_valid, res_valid, res_last, tx_ready;
  logic [7:0] echo_data, res_data;

  logic       echo_ready_o [3];
  logic       echo_drop_o  [3];
  logic       res_ready_o  [3];
  logic       tx_valid_o   [3];
  logic       msg_busy_o   [3];
  logic [7:0] tx_byte_o    [3];

  logic [7:0] q0[$], q1[$], q2[$], exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_sched #(
      .ECHO_DEPTH     ((g == 2) ? 8 : 4),
      .MAX_ECHO_BURST (4),
      .APPEND_CRLF    ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .echo_valid (echo_valid),
      .echo_data  (echo_data),
      .echo_ready (echo_ready_o[g]),
      .echo_drop  (echo_drop_o[g]),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_last   (res_last),
      .res_ready  (res_ready_o[g]),
      .tx_valid   (tx_valid_o[g]),
      .tx_byte    (tx_byte_o[g]),
      .tx_ready   (tx_ready),
      .msg_busy   (msg_busy_o[g])
    );
  end

  // Record every byte handed to the transmitter (inputs are stable at negedge)
  always @(negedge clk) if (tx_valid_o[0] && tx_ready) q0.push_back(tx_byte_o[0]);
  always @(negedge clk) if (tx_valid_o[1] && tx_ready) q1.push_back(tx_byte_o[1]);
  always @(negedge clk) if (tx_valid_o[2] && tx_ready) q2.push_back(tx_byte_o[2]);

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    n_rst = 1'b0; echo_valid = 1'b0; res_valid = 1'b0; res_last = 1'b0;
    tx_ready = 1'b0; echo_data = 8'h00; res_data = 8'h00;
    tick();
    n_rst = 1'b1;
    tick();
    clear_q();
  endtask

  // Offer one result byte and wait (bounded) until instance sel accepts it
  task automatic put_res(input int sel, input logic [7:0] d, input logic last);
    int t;
    res_valid = 1'b1; res_data = d; res_last = last;
    #1;
    t = 0;
    while (!res_ready_o[sel] && t < 200) begin
      tick(); #1; t++;
    end
    chk($sformatf("res_wait_%0h", d), 32'(t < 200), 32'd1);
    tick();
  endtask

  task automatic check_q(input int sel, input string tag);
    logic [7:0] got[$];
    if (sel == 0) got = q0; else if (sel == 1) got = q1; else got = q2;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    // Reset state
    n_rst = 1'b0; echo_valid = 1'b0; res_valid = 1'b0; res_last = 1'b0;
    tx_ready = 1'b0; echo_data = 8'h00; res_data = 8'h00;
    ticks(2);
    chk("rst_tx_valid", 32'(tx_valid_o[0]), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte_o[0]), 32'h00);
    chk("rst_msg_busy", 32'(msg_busy_o[0]), 32'd0);
    chk("rst_echo_drop", 32'(echo_drop_o[0]), 32'd0);
    chk("rst_echo_ready", 32'(echo_ready_o[0]), 32'd1);
    n_rst = 1'b1;
    tick();
    clear_q();

    // 1: echo only, one-cycle latency, back-to-back bytes
    tx_ready = 1'b1;
    echo_valid = 1'b1; echo_data = 8'h41;
    tick();
    chk("t1_lat_valid", 32'(tx_valid_o[0]), 32'd0);
    echo_data = 8'h42;
    tick();
    echo_valid = 1'b0;
    chk("t1_v0", 32'(tx_valid_o[0]), 32'd1);
    chk("t1_b0", 32'(tx_byte_o[0]), 32'h41);
    tick();
    chk("t1_v1", 32'(tx_valid_o[0]), 32'd1);
    chk("t1_b1", 32'(tx_byte_o[0]), 32'h42);
    tick();
    chk("t1_idle", 32'(tx_valid_o[0]), 32'd0);

    // 2: message 30..37 with CR/LF; echo 'x' pushed mid-message goes after LF
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin echo_valid = 1'b1; echo_data = 8'h78; end
      put_res(0, 8'(8'h30 + i), (i == 7));
      echo_valid = 1'b0;
      if (i == 4) chk("t2_busy_mid", 32'(msg_busy_o[0]), 32'd1);
    end
    res_valid = 1'b0; res_last = 1'b0;
    ticks(8);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0D, 8'h0A, 8'h78};
    check_q(0, "t2_seq");
    chk("t2_busy_end", 32'(msg_busy_o[0]), 32'd0);

    // 3: fairness on the depth-8 instance; e0 is already in the output register
    do_reset();
    for (int i = 0; i < 7; i++) begin
      echo_valid = 1'b1; echo_data = 8'(8'h61 + i);
      tick();
    end
    echo_valid = 1'b0;
    tx_ready = 1'b1;
    put_res(2, 8'h50, 1'b0);
    put_res(2, 8'h51, 1'b1);
    res_valid = 1'b0; res_last = 1'b0;
    ticks(12);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h50, 8'h51, 8'h0D, 8'h0A, 8'h66, 8'h67};
    check_q(2, "t3_fair");

    // 4: backpressure mid-message, then echo overflow while stalled
    do_reset();
    tx_ready = 1'b1;
    put_res(0, 8'h40, 1'b0);
    put_res(0, 8'h41, 1'b0);
    put_res(0, 8'h42, 1'b0);
    tx_ready = 1'b0;
    res_data = 8'h43; res_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", 32'(tx_valid_o[0]), 32'd1);
      chk("t4_hold_byte", 32'(tx_byte_o[0]), 32'h42);
      chk("t4_res_ready", 32'(res_ready_o[0]), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      echo_valid = 1'b1; echo_data = 8'(8'h71 + i);
      if (i == 4) chk("t4_full", 32'(echo_ready_o[0]), 32'd0);
      if (i == 3) chk("t4_nodrop", 32'(echo_drop_o[0]), 32'd0);
      tick();
    end
    echo_valid = 1'b0;
    chk("t4_drop_pulse", 32'(echo_drop_o[0]), 32'd1);
    tick();
    chk("t4_drop_end", 32'(echo_drop_o[0]), 32'd0);
    tx_ready = 1'b1;
    put_res(0, 8'h43, 1'b1);
    res_valid = 1'b0; res_last = 1'b0;
    ticks(12);
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A, 8'h71, 8'h72, 8'h73, 8'h74};
    check_q(0, "t4_seq");

    // 5a: single-byte message, with and without suffix
    do_reset();
    tx_ready = 1'b1;
    put_res(0, 8'h55, 1'b1);
    res_valid = 1'b0; res_last = 1'b0;
    chk("t5_busy_crlf", 32'(msg_busy_o[0]), 32'd1);
    chk("t5_busy_nocrlf", 32'(msg_busy_o[1]), 32'd0);
    ticks(6);
    exp_q = '{8'h55, 8'h0D, 8'h0A};
    check_q(0, "t5_crlf");
    exp_q = '{8'h55};
    check_q(1, "t5_nocrlf");
    chk("t5_busy_done", 32'(msg_busy_o[0]), 32'd0);

    // 5b: push and pop together with three bytes buffered keeps the count
    do_reset();
    for (int i = 0; i < 4; i++) begin
      echo_valid = 1'b1; echo_data = 8'(8'hA0 + i);
      tick();
    end
    echo_data = 8'hA4; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; echo_valid = 1'b0;
    chk("t5_pushpop_ready", 32'(echo_ready_o[0]), 32'd1);
    echo_valid = 1'b1; echo_data = 8'hA5;
    tick();
    echo_valid = 1'b0;
    chk("t5_now_full", 32'(echo_ready_o[0]), 32'd0);
    tx_ready = 1'b1;
    ticks(8);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    check_q(0, "t5_order");

    // 6: reset mid-message discards message and buffered echo
    do_reset();
    tx_ready = 1'b1;
    put_res(0, 8'h30, 1'b0);
    put_res(0, 8'h31, 1'b0);
    put_res(0, 8'h32, 1'b0);
    echo_valid = 1'b1; echo_data = 8'h7A;
    res_data = 8'h33;
    tick();
    echo_valid = 1'b0; res_valid = 1'b0;
    n_rst = 1'b0;
    tick();
    chk("t6_rst_valid", 32'(tx_valid_o[0]), 32'd0);
    chk("t6_rst_busy", 32'(msg_busy_o[0]), 32'd0);
    n_rst = 1'b1;
    tick();
    clear_q();
    put_res(0, 8'h61, 1'b1);
    res_valid = 1'b0; res_last = 1'b0;
    ticks(6);
    exp_q = '{8'h61, 8'h0D, 8'h0A};
    check_q(0, "t6_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
